reg_bank: RTL
=============

Name: reg_bank

Overview:
- General-purpose register storage for the single-cycle MIPS datapath.
- Holds 32 × 32-bit registers and accepts one write per clock from the writeback stage.
- Drives two combinational read ports, rs and rt, into the decode/ALU operand path, plus one debug read port.
- Register 0 is architecturally zero: always reads 0, writes to it are discarded.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register index width; equals log2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable from writeback.
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  value to write.
- rd_addr_a  in  ADDR_W  rs index.
- rd_data_a  out  DATA_W  rs value.
- rd_addr_b  in  ADDR_W  rt index.
- rd_data_b  out  DATA_W  rt value.
- dbg_addr  in  ADDR_W  debug/testbench read index.
- dbg_data  out  DATA_W  debug read value.
- dbg_written  out  1  1 if register dbg_addr has been written since reset.
- wr_count  out  16  number of accepted (non-x0) writes since reset, saturating.

Behaviour:
Reset
- Reset is asynchronous, active-low: on rst_n=0, registers 1..31, the written bitmap and wr_count clear to 0 immediately, without waiting for clk.
- Consequently all read outputs show 0 while in reset.
- Writes are ignored while rst_n=0.
- Reset asserted mid-write: reset wins; the register holds 0 after release.

Write
- A write is accepted on a rising clk when we=1, wr_addr!=0 and rst_n=1.
- On an accepted write: reg[wr_addr] <= wr_data, written[wr_addr] <= 1, and wr_count increments by 1, saturating at 16'hFFFF.
- we=1 with wr_addr=0: no state change at all; wr_count does not increment.
- Exactly one write port, so there are no write-write conflicts.

Read
- Read ports are purely combinational, with zero-cycle latency.
- rd_data_x = 0 when rd_addr_x=0, otherwise reg[rd_addr_x].
- dbg_data follows the same rule; dbg_written = written[dbg_addr], and is always 0 for address 0.
- Read and write of the same address in the same cycle (no bypass): the read returns the old value until the edge and the new value after it.
- All read ports may address the same register simultaneously.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined: write-through bypass. When we=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data in the same cycle, before the edge. This applies to ports a and b only; dbg is never bypassed.
- Undefined: reads always reflect stored state as described under Behaviour.
- The x0 rule has priority over the bypass in both configurations.

Decomposition:
- Shared package mips_pkg:
  - REG_ZERO = 5'd0.
  - DATA_W and ADDR_W constants.
  - typedefs reg_idx_t (ADDR_W bits) and word_t (DATA_W bits).
- Sub-module reg_bank_rd_port:
  - Parameterised N:1 read selector with the built-in zero-for-index-0 rule.
  - Instantiated three times: a, b and dbg.
- Storage, the written bitmap and the counter stay in the top module.

Test Plan:
- Reset check: rst_n=0 mid-cycle, then release -> reads at all 32 addresses = 0; dbg_written=0 everywhere; wr_count=0.
- Basic write/read: write 0xDEADBEEF to r8, then read a=8, b=8 -> both 0xDEADBEEF; dbg_written(8)=1; wr_count=1.
- x0 protection: we=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_addr_a=0 reads 0; wr_count unchanged.
- Same-cycle read/write of r5 (old value 0x11, new value 0x22):
  - Without bypass: 0x11 before the edge, 0x22 after.
  - With REG_BANK_BYPASS_EN: 0x22 before the edge.
- Asynchronous reset between clock edges after writing r31=0x12345678 -> r31 reads 0 immediately, without a clock edge.
- Sweep and saturation:
  - Write i*0x01010101 to r1..r31, then read all of them back on both ports -> exact match.
  - Force 70000 writes -> wr_count = 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and types
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // True for the architecturally hardwired zero register
  function automatic logic is_reg_zero(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// rtl/reg_bank_rd_port.sv - N:1 register read selector with index-0 reads forced to zero
module reg_bank_rd_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // select the addressed entry; index 0 always reads as zero regardless of storage
  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 32x32 MIPS register bank, 1 write / 2 read / 1 debug port; REG_BANK_BYPASS_EN adds write-through bypass on ports a and b
module reg_bank
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_written,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] written_q;
  logic [15:0]         wr_count_q;
  logic                wr_accept;

  logic [DATA_W-1:0]   port_a_data;
  logic [DATA_W-1:0]   port_b_data;
  logic [DATA_W-1:0]   port_dbg_data;

  // writes to the zero register are dropped entirely, including the count
  assign wr_accept = we && (wr_addr != ZERO_IDX);

  // register storage; entry 0 is cleared on reset and never written afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_accept) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // per-register "written since reset" flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (wr_accept) begin
      written_q[wr_addr] <= 1'b1;
    end
  end

  // accepted-write counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else if (wr_accept && (wr_count_q != CNT_MAX)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  reg_bank_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_port_a (
    .regs (regs_q),
    .addr (rd_addr_a),
    .data (port_a_data)
  );

  reg_bank_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_port_b (
    .regs (regs_q),
    .addr (rd_addr_b),
    .data (port_b_data)
  );

  reg_bank_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_port_dbg (
    .regs (regs_q),
    .addr (dbg_addr),
    .data (port_dbg_data)
  );

`ifdef REG_BANK_BYPASS_EN
  // forward the in-flight write to the operand ports; gated by rst_n so reset reads stay zero,
  // and wr_accept already excludes index 0 so the zero rule keeps priority
  logic bypass_a;
  logic bypass_b;

  assign bypass_a  = rst_n && wr_accept && (rd_addr_a == wr_addr);
  assign bypass_b  = rst_n && wr_accept && (rd_addr_b == wr_addr);
  assign rd_data_a = bypass_a ? wr_data : port_a_data;
  assign rd_data_b = bypass_b ? wr_data : port_b_data;
`else
  assign rd_data_a = port_a_data;
  assign rd_data_b = port_b_data;
`endif

  // debug port always shows stored state, never the in-flight write
  assign dbg_data    = port_dbg_data;
  assign dbg_written = (dbg_addr != ZERO_IDX) && written_q[dbg_addr];
  assign wr_count    = wr_count_q;

endmodule
